// File: rtl/time_edit_ctrl.sv
// Time-setting controller: IDLE shows live RTC time, LOAD/EDIT adjust a BCD copy, COMMIT writes it back.
// Optional macro TIME_EDIT_TIMEOUT_EN enables an idle-abort counter in EDIT (TIMEOUT_CYCLES).
module time_edit_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog_req,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [7:0] rtc_hour,
  input  logic [7:0] rtc_min,
  input  logic [7:0] rtc_sec,
  output logic [7:0] hour_out1,
  output logic [7:0] hour_out2,
  output logic [7:0] hour_out3,
  output logic       programar_on,
  output logic [3:0] direccion_actual_pantalla,
  output logic       wr_req,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ack
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] EDIT   = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX   = 8'h59;

  logic [1:0] state;
  logic [7:0] live_hour, live_min, live_sec;
  logic [7:0] edit_hour, edit_min, edit_sec;
  logic [1:0] field;
  logic [1:0] index;
  logic       gap;

  logic       step_up, step_down, move_left, move_right;
  logic [7:0] sel_val, sel_max, sel_next;
  logic [1:0] field_next;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00) return max;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return v - 8'd1;
  endfunction

  // Anything that is not a legal BCD value within range loads as zero.
  function automatic logic [7:0] bcd_fix(input logic [7:0] v, input logic [7:0] max);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max) return 8'h00;
    return v;
  endfunction

  assign step_up    = btn_up & ~btn_down;
  assign step_down  = btn_down & ~btn_up;
  assign move_right = btn_right & ~btn_left;
  assign move_left  = btn_left & ~btn_right;

  always_comb begin
    sel_val = edit_sec;
    sel_max = MS_MAX;
    case (field)
      2'd0: begin
        sel_val = edit_hour;
        sel_max = HOUR_MAX;
      end
      2'd1: sel_val = edit_min;
      default: sel_val = edit_sec;
    endcase
    sel_next = sel_val;
    if (step_up) sel_next = bcd_inc(sel_val, sel_max);
    else if (step_down) sel_next = bcd_dec(sel_val, sel_max);

    field_next = field;
    if (move_right) field_next = (field == 2'd2) ? 2'd0 : field + 2'd1;
    else if (move_left) field_next = (field == 2'd0) ? 2'd2 : field - 2'd1;
  end

`ifdef TIME_EDIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt;
  logic             any_btn;
  logic             timed_out;

  assign any_btn   = btn_up | btn_down | btn_left | btn_right;
  assign timed_out = !any_btn && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // The counter only runs in EDIT and never passes TIMEOUT_CYCLES-1, so it cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (state == LOAD) begin
      idle_cnt <= '0;
    end else if (state == EDIT) begin
      if (any_btn || timed_out) idle_cnt <= '0;
      else idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  logic timed_out;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      live_hour <= 8'h00;
      live_min  <= 8'h00;
      live_sec  <= 8'h00;
      edit_hour <= 8'h00;
      edit_min  <= 8'h00;
      edit_sec  <= 8'h00;
      field     <= 2'd0;
      index     <= 2'd0;
      gap       <= 1'b0;
    end else begin
      live_hour <= rtc_hour;
      live_min  <= rtc_min;
      live_sec  <= rtc_sec;
      case (state)
        IDLE: begin
          if (prog_req) state <= LOAD;
        end
        LOAD: begin
          edit_hour <= bcd_fix(rtc_hour, HOUR_MAX);
          edit_min  <= bcd_fix(rtc_min, MS_MAX);
          edit_sec  <= bcd_fix(rtc_sec, MS_MAX);
          field     <= 2'd0;
          state     <= EDIT;
        end
        EDIT: begin
          if (prog_req) begin
            state <= COMMIT;
            index <= 2'd0;
            gap   <= 1'b0;
          end else if (timed_out) begin
            state <= IDLE;
            field <= 2'd0;
          end else begin
            case (field)
              2'd0: edit_hour <= sel_next;
              2'd1: edit_min  <= sel_next;
              default: edit_sec <= sel_next;
            endcase
            field <= field_next;
          end
        end
        default: begin
          // One dead cycle after every acknowledge before the next byte goes out.
          if (gap) begin
            gap <= 1'b0;
            if (index == 2'd2) begin
              state <= IDLE;
              index <= 2'd0;
              field <= 2'd0;
            end else begin
              index <= index + 2'd1;
            end
          end else if (wr_ack) begin
            gap <= 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    hour_out1                 = live_hour;
    hour_out2                 = live_min;
    hour_out3                 = live_sec;
    programar_on              = 1'b0;
    direccion_actual_pantalla = 4'd0;
    wr_req                    = 1'b0;
    wr_addr                   = 2'd0;
    wr_data                   = 8'h00;
    if (state != IDLE) begin
      hour_out1                 = edit_hour;
      hour_out2                 = edit_min;
      hour_out3                 = edit_sec;
      programar_on              = 1'b1;
      direccion_actual_pantalla = {2'b00, field};
    end
    if (state == COMMIT) begin
      wr_req  = !gap;
      wr_addr = index;
      case (index)
        2'd0: wr_data = edit_hour;
        2'd1: wr_data = edit_min;
        default: wr_data = edit_sec;
      endcase
    end
  end

endmodule
